// File: rtl/clock_divider_monitor.sv
// Measures high/low phase lengths of a divided clock sampled in the clk_in domain,
// judges them against an expected half-period and reports lock, errors and an error count.
module clock_divider_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_half,
  output logic [CNT_W-1:0] half_len,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, ACQ, CHECK, LOCKED} state_t;

  localparam logic [4:0] LOCK_TARGET = 5'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic             sig_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] half_len_q, half_len_d;
  logic [3:0]       good_q, good_d;
  logic             stuck_q, stuck_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_count_q, err_count_d;

  logic       sig_edge;
  logic       monitoring;
  logic       measure;
  logic       stuck_hit;
  logic       judged;
  logic       match;
  logic [4:0] good_inc;

  assign sig_edge   = (sig_in != sig_q);
  assign monitoring = enable && ((state_q == CHECK) || (state_q == LOCKED));
  // The edge closing a stuck run is dropped; a coinciding edge always beats the stuck check.
  assign measure    = monitoring && sig_edge && !stuck_q;
  assign stuck_hit  = monitoring && !sig_edge && !stuck_q && (run_cnt_q == exp_q);
  assign judged     = measure || stuck_hit;
  assign match      = measure && (run_cnt_q == exp_q);
  assign good_inc   = {1'b0, good_q} + 5'd1;

  always_comb begin
    if (sig_edge)
      run_cnt_d = CNT_W'(1);
    else if (run_cnt_q == '1)
      run_cnt_d = run_cnt_q;
    else
      run_cnt_d = run_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      sig_q        <= 1'b0;
      run_cnt_q    <= '0;
      exp_q        <= '0;
      half_len_q   <= '0;
      good_q       <= '0;
      stuck_q      <= 1'b0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_in;
      run_cnt_q    <= run_cnt_d;
      exp_q        <= exp_d;
      half_len_q   <= half_len_d;
      good_q       <= good_d;
      stuck_q      <= stuck_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (exp_half != '0) state_d = ACQ;
        ACQ:     if (sig_edge) state_d = CHECK;
        CHECK:   if (match && (good_inc == LOCK_TARGET)) state_d = LOCKED;
        LOCKED:  if (judged && !match) state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    exp_d        = exp_q;
    good_d       = good_q;
    stuck_d      = stuck_q;
    half_len_d   = half_len_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    locked_d     = (state_d == LOCKED);

    if (!enable || (state_q == IDLE)) begin
      good_d  = '0;
      stuck_d = 1'b0;
    end
    if (enable && (state_q == IDLE) && (exp_half != '0))
      exp_d = exp_half;

    if (monitoring && sig_edge && stuck_q)
      stuck_d = 1'b0;
    if (stuck_hit)
      stuck_d = 1'b1;

    if (measure) begin
      half_len_d   = run_cnt_q;
      meas_valid_d = 1'b1;
    end

    if (judged) begin
      if (match) begin
        if (state_q == CHECK)
          good_d = good_inc[3:0];
      end else begin
        good_d = '0;
        if (state_q == LOCKED) begin
          err_d = 1'b1;
          if (err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
        end
      end
    end
  end

  assign half_len   = half_len_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_clock_divider_monitor.sv
// Randomized and directed bench for clock_divider_monitor, checked every cycle against
// a reference model that tracks edge timestamps and phase-level rules.
module tb_clock_divider_monitor;

  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_CHECK  = 2;
  localparam int M_LOCKED = 3;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] exp_half;
  logic [CNT_W-1:0] half_len;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;

  always #5 clk_in = ~clk_in;

  clock_divider_monitor #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .sig_in     (sig_in),
    .exp_half   (exp_half),
    .half_len   (half_len),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit curEn  = 1'b0;
  bit curSig = 1'b0;
  int curEh  = 0;

  int mMode     = M_IDLE;
  bit mPrevSig  = 1'b0;
  int mLastEdge = 0;
  int mExp      = 0;
  int mGood     = 0;
  bit mStuck    = 1'b0;
  int eHalf     = 0;
  int eValid    = 0;
  int eLocked   = 0;
  int eErr      = 0;
  int eCount    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // A judged phase: good phases build toward lock, a bad one while locked is an error.
  task automatic modelJudge(input bit ok);
    if (mMode == M_CHECK) begin
      if (ok) begin
        mGood++;
        if (mGood == LOCK_COUNT) mMode = M_LOCKED;
      end else begin
        mGood = 0;
      end
    end else if (!ok) begin
      eErr = 1;
      if (eCount < 255) eCount++;
      mGood = 0;
      mMode = M_CHECK;
    end
  endtask

  task automatic modelStep(input bit r, input bit en, input bit s, input int eh);
    bit isEdge;
    int held;
    if (r) begin
      mMode = M_IDLE; mPrevSig = 1'b0; mLastEdge = cyc + 1;
      mExp = 0; mGood = 0; mStuck = 1'b0;
      eHalf = 0; eValid = 0; eLocked = 0; eErr = 0; eCount = 0;
      return;
    end
    isEdge = (s != mPrevSig);
    held   = cyc - mLastEdge;
    if (held > CNT_MAX) held = CNT_MAX;
    eValid = 0;
    eErr   = 0;
    if (!en) begin
      mMode = M_IDLE; mGood = 0; mStuck = 1'b0;
    end else if (mMode == M_IDLE) begin
      mGood = 0; mStuck = 1'b0;
      if (eh >= 1) begin
        mExp  = eh;
        mMode = M_ACQ;
      end
    end else if (mMode == M_ACQ) begin
      if (isEdge) mMode = M_CHECK;
    end else if (isEdge) begin
      if (mStuck) begin
        mStuck = 1'b0;
      end else begin
        eHalf  = held;
        eValid = 1;
        modelJudge(held == mExp);
      end
    end else if ((held == mExp) && !mStuck) begin
      mStuck = 1'b1;
      modelJudge(1'b0);
    end
    eLocked = (mMode == M_LOCKED) ? 1 : 0;
    if (isEdge) mLastEdge = cyc;
    mPrevSig = s;
  endtask

  task automatic applyStimulus(input bit rstVal);
    reset    = rstVal;
    enable   = curEn;
    sig_in   = curSig;
    exp_half = curEh[CNT_W-1:0];
    @(posedge clk_in);
    cyc++;
    modelStep(rstVal, curEn, curSig, curEh);
    #1;
    checkOutput("half_len", 32'(half_len), eHalf);
    checkOutput("meas_valid", 32'(meas_valid), eValid);
    checkOutput("locked", 32'(locked), eLocked);
    checkOutput("err", 32'(err), eErr);
    checkOutput("err_count", 32'(err_count), eCount);
  endtask

  task automatic runPhase(input int len);
    repeat (len) applyStimulus(1'b0);
    curSig = ~curSig;
  endtask

  initial begin
    int base;
    int len;
    int nph;
    int pick;

    curEn = 1'b0; curSig = 1'b0; curEh = 0;
    repeat (2) applyStimulus(1'b1);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_err_count", 32'(err_count), 0);

    curEn = 1'b1; curEh = 2;
    repeat (20) runPhase(2);
    checkOutput("t1_locked", 32'(locked), 1);
    checkOutput("t1_err_count", 32'(err_count), 0);

    curEn = 1'b0; applyStimulus(1'b0);
    curEn = 1'b1; curEh = 4;
    repeat (12) runPhase(4);
    checkOutput("t2_half4", 32'(half_len), 4);
    checkOutput("t2_locked4", 32'(locked), 1);
    curEn = 1'b0; applyStimulus(1'b0);
    curEn = 1'b1; curEh = 8;
    repeat (10) runPhase(8);
    checkOutput("t2_half8", 32'(half_len), 8);
    checkOutput("t2_locked8", 32'(locked), 1);

    applyStimulus(1'b1);
    curEh = 2;
    repeat (6) runPhase(2);
    runPhase(3);
    repeat (6) runPhase(2);
    checkOutput("t3_err_count", 32'(err_count), 1);
    checkOutput("t3_relocked", 32'(locked), 1);

    applyStimulus(1'b1);
    curEh = 4;
    repeat (8) runPhase(4);
    repeat (20) applyStimulus(1'b0);
    curSig = ~curSig;
    repeat (8) runPhase(4);
    checkOutput("t4_err_count", 32'(err_count), 1);

    applyStimulus(1'b1);
    curEh = 0;
    repeat (10) runPhase(2);
    checkOutput("t5_idle_locked", 32'(locked), 0);
    curEh = 2;
    repeat (5) runPhase(2);
    repeat (260) begin
      runPhase(3);
      repeat (4) runPhase(2);
    end
    checkOutput("t5_saturated", 32'(err_count), 255);

    applyStimulus(1'b1);
    repeat (6) runPhase(2);
    repeat (3) begin
      runPhase(3);
      repeat (4) runPhase(2);
    end
    checkOutput("t6_err_count3", 32'(err_count), 3);
    applyStimulus(1'b1);
    checkOutput("t6_rst_err_count", 32'(err_count), 0);
    checkOutput("t6_rst_half_len", 32'(half_len), 0);
    repeat (4) runPhase(2);
    curEn = 1'b0;
    repeat (2) applyStimulus(1'b0);
    checkOutput("t6_dis_locked", 32'(locked), 0);
    checkOutput("t6_dis_half_len", 32'(half_len), 2);

    // Random blocks: jittered phases, stuck runs, enable drops, resets and ignored exp_half changes.
    for (int blk = 0; blk < 60; blk++) begin
      if ($urandom_range(0, 9) == 0) applyStimulus(1'b1);
      pick = $urandom_range(0, 5);
      base = (pick == 5) ? 8 : pick + 1;
      curEn = 1'b0; applyStimulus(1'b0);
      curEn = 1'b1;
      curEh = ($urandom_range(0, 15) == 0) ? 0 : base;
      applyStimulus(1'b0);
      nph = $urandom_range(6, 16);
      for (int p = 0; p < nph; p++) begin
        len  = base;
        pick = $urandom_range(0, 11);
        if (pick == 0) len = base + $urandom_range(2, 6);
        else if (pick == 1) len = base + 1;
        else if (pick == 2 && base > 1) len = base - 1;
        if ($urandom_range(0, 7) == 0) curEh = $urandom_range(1, 10);
        if ($urandom_range(0, 24) == 0) curEn = 1'b0;
        else curEn = 1'b1;
        runPhase(len);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_monitor.md
Name: clock_divider_monitor

Overview:
- Checks one divided-clock output from the clock generator, such as clk_out1, clk_out2 or clk_out3.
- The monitored signal is sampled as data in the clk_in domain. The block measures the length of each high and low phase in clk_in cycles and compares it with an expected half-period.
- It reports lock, per-phase errors and a saturating error count. Bring-up logic and self-test logic use these to qualify the generated clocks.

Parameters:
- CNT_W, 8: width of the phase-length counter, exp_half and half_len.
- LOCK_COUNT, 4: number of consecutive correct phases needed to assert locked (1 to 15).

Ports:
- clk_in  input  1  system clock, same clock that drives the clock generator.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run monitor; low forces IDLE.
- sig_in  input  1  monitored divided clock, synchronous to clk_in.
- exp_half  input  CNT_W  expected phase length in clk_in cycles; captured on the IDLE->ACQ transition.
- half_len  output  CNT_W  last measured phase length.
- meas_valid  output  1  one-cycle pulse when half_len updates.
- locked  output  1  LOCK_COUNT consecutive good phases seen.
- err  output  1  one-cycle pulse on a mismatch or stuck phase while LOCKED.
- err_count  output  8  saturating count of err pulses.

Behaviour:
- Clock, reset and output timing:
  - Single clock clk_in; reset is synchronous and active-high.
  - All outputs are registered.
  - Reset values: half_len=0, meas_valid=0, locked=0, err=0, err_count=0, state=IDLE.
- Edge detection and phase measurement:
  - sig_q registers sig_in every cycle, including in IDLE. An edge is sig_in != sig_q.
  - run_cnt is CNT_W bits. On an edge it loads 1; otherwise it increments, saturating at all-ones.
  - The measured length at an edge is the current run_cnt (cycles the previous level was held). A signal toggling every 2 cycles measures 2.
- States:
  - IDLE:
    - locked=0, good_cnt=0, stuck flag clear.
    - If enable=1 and exp_half>=1: capture exp_half into exp_r and go to ACQ.
    - If exp_half=0: stay in IDLE.
  - ACQ: the first edge goes to CHECK. That measurement is partial, so it is discarded: no meas_valid, half_len not updated.
  - CHECK, on an edge:
    - half_len<=measured and meas_valid=1 in the next cycle.
    - If measured==exp_r: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED with locked=1.
    - Otherwise good_cnt<=0 and stay in CHECK; no err is raised.
  - LOCKED, on an edge:
    - half_len and meas_valid update as in CHECK.
    - A mismatch gives an err pulse, err_count+1 (saturating at 255), good_cnt<=0, locked<=0 and a move to CHECK.
- Stuck detection (CHECK or LOCKED):
  - Trigger: run_cnt==exp_r with no edge in the same cycle, so the level has been held for exp_r+1 cycles, and the stuck flag is clear.
  - Action: set the stuck flag and treat it as a mismatch. In LOCKED this raises err and goes to CHECK; in CHECK it clears good_cnt.
  - The edge ending a stuck run clears the flag and is discarded: no measurement and no judgement.
  - At most one err per stuck run.
- enable deasserting in any state goes to IDLE on the next cycle. half_len and err_count are held; locked clears.
- Reset mid-operation returns everything to reset values on that clock edge, including err_count.
- exp_r is held constant outside IDLE; changes to exp_half there are ignored.
- If an edge and the stuck condition coincide, the edge wins: the run is not stuck.
- Latency: an edge at sampling cycle N gives meas_valid/half_len/err at cycle N+1.

Test Plan:
1. Reset, enable=1, exp_half=2, sig_in driven by clk_out1 of the clock generator -> meas_valid pulses every 2 cycles with half_len=2; locked asserts at the 5th edge after enable (1 discarded + 4 good); err_count stays 0.
2. exp_half=4 on clk_out2, then exp_half=8 on clk_out3 (enable cycled between runs) -> half_len=4 and 8 respectively; locked asserts; no err.
3. Locked on exp_half=2, one phase stretched to 3 cycles -> half_len=3, single err pulse, err_count=1, locked drops; relocks after 4 further good phases.
4. Locked on exp_half=4, sig_in held constant -> err exactly once, 5 cycles after the last edge; err_count=1; no further err while stuck; the recovery edge produces no meas_valid.
5. exp_half=0 with enable=1 -> stays IDLE, locked=0, no meas_valid. Then force 256 error events -> err_count saturates at 255.
6. Reset asserted mid-LOCKED with err_count=3 -> next cycle all outputs 0, state IDLE. enable dropped mid-CHECK -> locked=0, half_len retained.
